bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/bus_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types for the bus arbiter: the transaction FSM state encoding.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans requests starting at rr_ptr,
// wrapping at NUM_MASTERS-1 -> 0, and returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int PTR_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       rr_ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [PTR_W-1:0]       gnt_idx
);

  // First requester at or after rr_ptr (circularly) wins.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting NUM_MASTERS requesters access to one shared
// bus. Winner's request fields are latched at grant time, so a master that
// drops m_req mid-transaction cannot disturb the bus. A bounded wait on
// bus_ready turns a hung slave into an m_err pulse instead of a deadlock.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_rnw,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [NUM_MASTERS-1:0]            m_done,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              bus_valid,
  output logic                              bus_rnw,
  output logic [ADDR_WIDTH-1:0]             bus_addr,
  output logic [DATA_WIDTH-1:0]             bus_wdata,
  input  logic                              bus_ready,
  input  logic [DATA_WIDTH-1:0]             bus_rdata
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e state_q, state_d;

  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0]       wait_q, wait_d;
  logic [NUM_MASTERS-1:0] m_gnt_q, m_gnt_d;
  logic [NUM_MASTERS-1:0] m_done_q, m_done_d;
  logic [NUM_MASTERS-1:0] m_err_q, m_err_d;
  logic [DATA_WIDTH-1:0]  m_rdata_q, m_rdata_d;
  logic                   bus_valid_q, bus_valid_d;
  logic                   bus_rnw_q, bus_rnw_d;
  logic [ADDR_WIDTH-1:0]  bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0]  bus_wdata_q, bus_wdata_d;

  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [PTR_W-1:0]       arb_idx;
  logic                   any_req;
  logic                   bus_done;
  logic                   timeout_hit;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .PTR_W       (PTR_W)
  ) u_rr_arbiter (
    .req     (m_req),
    .rr_ptr  (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign any_req     = |m_req;
  // bus_ready only counts while we are actually driving a request.
  assign bus_done    = (state_q == ST_ACTIVE) && bus_valid_q && bus_ready;
  // Last allowed wait cycle: ACTIVE lasts exactly TIMEOUT cycles when unanswered.
  assign timeout_hit = (state_q == ST_ACTIVE) && !bus_ready &&
                       (wait_q == CNT_W'(TIMEOUT - 1));

  // State and datapath registers, cleared asynchronously so a reset mid-ACTIVE drops bus_valid at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      wait_q      <= '0;
      m_gnt_q     <= '0;
      m_done_q    <= '0;
      m_err_q     <= '0;
      m_rdata_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_rnw_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      wait_q      <= wait_d;
      m_gnt_q     <= m_gnt_d;
      m_done_q    <= m_done_d;
      m_err_q     <= m_err_d;
      m_rdata_q   <= m_rdata_d;
      bus_valid_q <= bus_valid_d;
      bus_rnw_q   <= bus_rnw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Next-state logic for the transaction FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_ARB;
      ST_ARB:    state_d = any_req ? ST_ACTIVE : ST_IDLE;
      ST_ACTIVE: begin
        if (bus_done)         state_d = ST_RESP;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output/datapath updates: latch the winner, count waits, emit done/err pulses, advance rr_ptr.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    wait_d      = wait_q;
    m_gnt_d     = m_gnt_q;
    m_done_d    = '0;
    m_err_d     = '0;
    m_rdata_d   = m_rdata_q;
    bus_valid_d = bus_valid_q;
    bus_rnw_d   = bus_rnw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    unique case (state_q)
      ST_ARB: begin
        if (any_req) begin
          m_gnt_d     = arb_gnt;
          grant_idx_d = arb_idx;
          bus_valid_d = 1'b1;
          wait_d      = '0;
          for (int i = 0; i < NUM_MASTERS; i++) begin
            if (arb_gnt[i]) begin
              bus_rnw_d   = m_rnw[i];
              bus_addr_d  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              bus_wdata_d = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
      ST_ACTIVE: begin
        if (bus_done) begin
          bus_valid_d = 1'b0;
          m_done_d    = m_gnt_q;
          if (bus_rnw_q) m_rdata_d = bus_rdata;
        end else if (timeout_hit) begin
          // Advancing past the grantee keeps a dead slave path from starving the rest.
          bus_valid_d = 1'b0;
          m_err_d     = m_gnt_q;
          m_gnt_d     = '0;
          rr_ptr_d    = next_ptr(grant_idx_q);
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        m_gnt_d  = '0;
        rr_ptr_d = next_ptr(grant_idx_q);
      end
      default: ;
    endcase
  end

  assign m_gnt     = m_gnt_q;
  assign m_done    = m_done_q;
  assign m_err     = m_err_q;
  assign m_rdata   = m_rdata_q;
  assign bus_valid = bus_valid_q;
  assign bus_rnw   = bus_rnw_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule
